// File: rtl/bw_seq_divider.sv
// Sequential signed restoring divider, one quotient bit per clock.
// Optional macro BWDIV_FAST_PATH_EN: zero divisor/dividend skips CALC/FIX.
module bw_seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    FAST
  } state_t;

  state_t state, nxt;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] mag;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic             neg_q;
  logic             neg_r;
  logic             dz;
  logic             ov;

  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] diff;
  logic             ge;
  logic             fast;

`ifdef BWDIV_FAST_PATH_EN
  assign fast = (divisor == '0) || (dividend == '0);
`else
  assign fast = 1'b0;
`endif

  assign rem_sh = {rem, mag[WIDTH-1]};
  assign diff   = rem_sh - {2'b00, dsr};
  assign ge     = ~diff[WIDTH+1];
  assign busy   = (state == CALC) || (state == FIX);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state decode
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start) nxt = fast ? FAST : CALC;
      CALC: if (count == LAST) nxt = FIX;
      FIX:  nxt = IDLE;
      FAST: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Operand capture, restoring iteration and sign fix-up
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count       <= '0;
      dvd_r       <= '0;
      mag         <= '0;
      dsr         <= '0;
      rem         <= '0;
      quo         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      ov          <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            dvd_r       <= dividend;
            mag         <= dividend[WIDTH-1] ? -dividend : dividend;
            dsr         <= divisor[WIDTH-1] ? -divisor : divisor;
            rem         <= '0;
            quo         <= '0;
            count       <= '0;
            neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r       <= dividend[WIDTH-1];
            dz          <= (divisor == '0);
            ov          <= (dividend == MOST_NEG) && (divisor == '1);
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        CALC: begin
          rem   <= ge ? diff[WIDTH:0] : rem_sh[WIDTH:0];
          quo   <= {quo[WIDTH-2:0], ge};
          mag   <= {mag[WIDTH-2:0], 1'b0};
          count <= count + 1'b1;
        end
        FIX, FAST: begin
          if (dz) begin
            quotient  <= '1;
            remainder <= dvd_r;
          end else begin
            quotient  <= neg_q ? -quo : quo;
            remainder <= neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
          end
          div_by_zero <= dz;
          overflow    <= ov;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bw_seq_divider.sv
// Scoreboard bench for bw_seq_divider at WIDTH=4.
// Integer reference model; monitor pops on each done.
module tb_bw_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  bw_seq_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t model(int a, int b);
    exp_t e;
    int   q;
    int   r;
    e.dz = 1'b0;
    e.ov = 1'b0;
    if (b == 0) begin
      q    = -1;
      r    = a;
      e.dz = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      if (q > (1 << (W - 1)) - 1) e.ov = 1'b1;
    end
    e.q = W'(q);
    e.r = W'(r);
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: compare each done against the oldest expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
        chk("overflow", 32'(overflow), 32'(e.ov));
      end
    end
  end

  task automatic idle(int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic op(input int a, input int b, input bit glitch);
    int n;
    int nbusy;
    bit seen;
    bit fast;
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    nbusy = 0;
    seen = 1'b0;
    while (!seen && n < 30) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) seen = 1'b1;
      else if (busy === 1'b1) nbusy++;
      if (glitch && n == 2) begin
        start    = 1'b1;
        dividend = W'(1);
        divisor  = W'(1);
      end
      if (glitch && n == 3) start = 1'b0;
    end
    fast = 1'b0;
`ifdef BWDIV_FAST_PATH_EN
    fast = (a == 0) || (b == 0);
`endif
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(n), fast ? 32'd2 : 32'(W + 2));
    chk("busy_cycles", 32'(nbusy), fast ? 32'd0 : 32'(W + 1));
    chk("busy_in_done", 32'(busy), 32'd0);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_q"}, 32'(quotient), 32'd0);
    chk({tag, "_r"}, 32'(remainder), 32'd0);
    chk({tag, "_dz"}, 32'(div_by_zero), 32'd0);
    chk({tag, "_ov"}, 32'(overflow), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    idle(3);
    chk_zero("reset");
    rst_n = 1'b1;
    idle(1);

    op(7, 2, 0);
    idle(3);
    chk("hold_q", 32'(quotient), 32'd3);
    chk("hold_r", 32'(remainder), 32'd1);
    op(-7, 2, 0);
    op(7, -2, 0);
    idle(1);
    op(-8, -1, 0);
    op(-8, 3, 0);
    idle(1);
    op(5, 0, 0);
    op(0, 3, 0);
    op(-8, 1, 0);
    op(7, -8, 0);
    op(-1, 7, 0);
    idle(1);

    dividend = W'(6);
    divisor  = W'(3);
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("abort");
    rst_n = 1'b1;
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);

    op(6, 3, 0);
    idle(1);
    op(7, 2, 1);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      int a;
      int b;
      a = int'($urandom_range(0, 15)) - 8;
      b = int'($urandom_range(0, 15)) - 8;
      op(a, b, 0);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end

    idle(12);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
